// File: rtl/divider_seq_param.sv
// Multi-cycle restoring divider (one quotient bit per cycle) with signed/unsigned,
// word mode, RISC-V divide-by-zero/overflow results, flush and a valid/ready handshake.
module divider_seq_param #(
  parameter int XLEN  = 64,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] op_1_i,
  input  logic [XLEN-1:0] op_2_i,
  input  logic            signed_i,
  input  logic            word_i,
  input  logic            flush_i,
  input  logic            block_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int HALF = XLEN / 2;

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_e;

  state_e             state_q;
  logic [XLEN-1:0]    op1_q, op2_q;
  logic               signed_q, word_q;
  logic [XLEN-1:0]    rem_q, quo_q, div_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               q_neg_q, r_neg_q;
  logic [XLEN-1:0]    quotient_q, remainder_q;
  logic               resp_valid_q;

  // Word-mode results are sign-extended from bit W-1, unsigned ops included.
  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x, input logic w);
    return w ? {{HALF{x[HALF-1]}}, x[HALF-1:0]} : x;
  endfunction

  // Operand preparation, evaluated on the latched request while in PREP.
  logic [XLEN-1:0] mask, op1_w, op2_w, abs1, abs2, min_w;
  logic            sign1, sign2, div_zero, ovf;

  always_comb begin
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    mask     = word_q ? {{HALF{1'b0}}, {HALF{1'b1}}} : {XLEN{1'b1}};
    op1_w    = op1_q & mask;
    op2_w    = op2_q & mask;
    sign1    = signed_q & (word_q ? op1_q[HALF-1] : op1_q[XLEN-1]);
    sign2    = signed_q & (word_q ? op2_q[HALF-1] : op2_q[XLEN-1]);
    abs1     = sign1 ? ((~op1_w + XLEN'(1)) & mask) : op1_w;
    abs2     = sign2 ? ((~op2_w + XLEN'(1)) & mask) : op2_w;
    min_w    = word_q ? (XLEN'(1) << (HALF - 1)) : (XLEN'(1) << (XLEN - 1));
    div_zero = (op2_w == '0);
    ovf      = signed_q && (op1_w == min_w) && (op2_w == mask);
  end

  // One restoring step. Since rem < divisor, the trial lies in (-2^XLEN, 2^XLEN)
  // and XLEN+1 bits are enough to read its sign.
  logic            quo_msb, q_bit;
  logic [XLEN:0]   shifted, trial;
  logic [XLEN-1:0] rem_d, quo_d;

  always_comb begin
    quo_msb = word_q ? quo_q[HALF-1] : quo_q[XLEN-1];
    shifted = {rem_q, quo_msb};
    trial   = shifted - {1'b0, div_q};
    q_bit   = ~trial[XLEN];
    rem_d   = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    quo_d   = {quo_q[XLEN-2:0], q_bit};
  end

  logic [XLEN-1:0] quo_fix, rem_fix;

  always_comb begin
    quo_fix = q_neg_q ? (~quo_q + XLEN'(1)) : quo_q;
    rem_fix = r_neg_q ? (~rem_q + XLEN'(1)) : rem_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      op1_q        <= '0;
      op2_q        <= '0;
      signed_q     <= 1'b0;
      word_q       <= 1'b0;
      rem_q        <= '0;
      quo_q        <= '0;
      div_q        <= '0;
      cnt_q        <= '0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
      quotient_q   <= '0;
      remainder_q  <= '0;
      resp_valid_q <= 1'b0;
    end else if (flush_i) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
    end else if (!block_i) begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            op1_q    <= op_1_i;
            op2_q    <= op_2_i;
            signed_q <= signed_i;
            word_q   <= word_i;
            state_q  <= PREP;
          end
        end
        PREP: begin
          q_neg_q <= sign1 ^ sign2;
          r_neg_q <= sign1;
          rem_q   <= '0;
          quo_q   <= abs1;
          div_q   <= abs2;
          cnt_q   <= word_q ? CNT_W'(HALF) : CNT_W'(XLEN);
          if (div_zero) begin
            quotient_q   <= sext_w(mask, word_q);
            remainder_q  <= sext_w(op1_w, word_q);
            resp_valid_q <= 1'b1;
            state_q      <= DONE;
          end else if (ovf) begin
            quotient_q   <= sext_w(op1_w, word_q);
            remainder_q  <= '0;
            resp_valid_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            state_q <= CALC;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= FIX;
        end
        FIX: begin
          quotient_q   <= sext_w(quo_fix, word_q);
          remainder_q  <= sext_w(rem_fix, word_q);
          resp_valid_q <= 1'b1;
          state_q      <= DONE;
        end
        DONE: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = resp_valid_q;
  assign quotient_o   = quotient_q;
  assign remainder_o  = remainder_q;

endmodule

// File: tb/tb_divider_seq_param.sv
// Directed bench for divider_seq_param: results, latency, stall, backpressure, flush, reset.
module tb_divider_seq_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o;
  logic [63:0] op_1_i, op_2_i;
  logic        signed_i, word_i, flush_i, block_i;
  logic        resp_valid_o, resp_ready_i;
  logic [63:0] quotient_o, remainder_o;

  int n_tests = 0;
  int n_fail  = 0;

  divider_seq_param #(.XLEN(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .op_1_i       (op_1_i),
    .op_2_i       (op_2_i),
    .signed_i     (signed_i),
    .word_i       (word_i),
    .flush_i      (flush_i),
    .block_i      (block_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request and returns just after the edge that accepts it.
  task automatic start(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w);
    int tries = 0;
    while (!req_ready_o && tries < 200) begin
      tick();
      tries++;
    end
    if (!req_ready_o) check("start_ready", {63'd0, req_ready_o}, 64'd1);
    op_1_i      = a;
    op_2_i      = b;
    signed_i    = s;
    word_i      = w;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
  endtask

  // Counts edges until resp_valid_o is seen; -1 on timeout.
  task automatic wait_resp(output int lat);
    lat = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      lat++;
      if (resp_valid_o) return;
    end
    lat = -1;
  endtask

  task automatic release_resp();
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
  endtask

  task automatic run(input string tag, input logic [63:0] a, input logic [63:0] b,
                     input logic s, input logic w, input logic [63:0] exp_q,
                     input logic [63:0] exp_r, input int exp_lat);
    int lat;
    start(a, b, s, w);
    wait_resp(lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_q"}, quotient_o, exp_q);
    check({tag, "_r"}, remainder_o, exp_r);
    release_resp();
  endtask

  initial begin
    int lat;
    bit seen;
    rst = 1'b0; req_valid_i = 1'b0; op_1_i = '0; op_2_i = '0;
    signed_i = 1'b0; word_i = 1'b0; flush_i = 1'b0; block_i = 1'b0; resp_ready_i = 1'b0;
    repeat (3) tick();
    check("rst_valid", {63'd0, resp_valid_o}, 64'd0);
    check("rst_ready", {63'd0, req_ready_o}, 64'd1);
    check("rst_q", quotient_o, 64'd0);
    check("rst_r", remainder_o, 64'd0);
    rst = 1'b1;
    tick();

    run("udiv",    64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 66);
    run("sdiv_n7", -64'sd7, 64'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    run("sdiv_p7", 64'd7, -64'sd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 66);
    run("sdiv_nn", -64'sd100, -64'sd7, 1'b1, 1'b0, 64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    run("ubig",    64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0, 1'b0, 64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 66);
    run("divz",    64'h1234, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1);
    run("ovf",     64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
        64'h8000_0000_0000_0000, 64'd0, 1);
    run("wu",      64'hDEAD_0000_8000_0000, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd0, 34);
    run("ws",      64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, 1'b1,
        64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 34);
    run("wdivz",   64'h0000_0005_0000_0007, 64'h0000_0001_0000_0000, 1'b0, 1'b1,
        64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 1);

    // Stall for 5 cycles mid-CALC, then hold off the consumer for 10 cycles.
    start(64'd100, 64'd7, 1'b0, 1'b0);
    repeat (10) tick();
    block_i = 1'b1;
    repeat (5) tick();
    block_i = 1'b0;
    wait_resp(lat);
    check("blk_lat", 64'(lat + 15), 64'd71);
    check("blk_q", quotient_o, 64'd14);
    check("blk_r", remainder_o, 64'd2);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", {63'd0, resp_valid_o}, 64'd1);
      check("bp_ready", {63'd0, req_ready_o}, 64'd0);
      check("bp_q", quotient_o, 64'd14);
    end
    release_resp();

    // Flush in the middle of CALC.
    start(64'd1000, 64'd3, 1'b0, 1'b0);
    repeat (21) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("fl_ready", {63'd0, req_ready_o}, 64'd1);
    check("fl_valid", {63'd0, resp_valid_o}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      seen |= resp_valid_o;
    end
    check("fl_never_valid", {63'd0, seen}, 64'd0);
    run("post_fl", 64'd1000, 64'd3, 1'b0, 1'b0, 64'd333, 64'd1, 66);

    // Reset pulse mid-CALC clears outputs left over from the previous result.
    start(64'd500, 64'd7, 1'b0, 1'b0);
    repeat (10) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mr_valid", {63'd0, resp_valid_o}, 64'd0);
    check("mr_ready", {63'd0, req_ready_o}, 64'd1);
    check("mr_q", quotient_o, 64'd0);
    check("mr_r", remainder_o, 64'd0);
    run("post_rst", 64'd500, 64'd7, 1'b0, 1'b0, 64'd71, 64'd3, 66);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/divider_seq_param.md
Name: divider_seq_param

Overview:
- Parametrised multi-cycle integer divider for the execute stage; successor to the fixed 64-bit divider.
- Produces quotient and remainder, one bit per cycle, for signed and unsigned operands.
- Adds a word mode (XLEN/2 operation with a sign-extended result) and in-block handling of RISC-V divide-by-zero and signed-overflow cases.
- Adds flush and a full request/response handshake.

Parameters:
- XLEN, 64, operand/result width; must be even and >= 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-low: state is cleared at the rising edge where rst==0.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  block can accept a request (IDLE only).
- op_1_i  input  XLEN  dividend.
- op_2_i  input  XLEN  divisor.
- signed_i  input  1  1 = signed division (DIV/REM), 0 = unsigned.
- word_i  input  1  1 = operate on low XLEN/2 bits (DIVW-class).
- flush_i  input  1  abort any operation in flight.
- block_i  input  1  pipeline stall: freeze all state.
- resp_valid_o  output  1  result valid.
- resp_ready_i  input  1  consumer takes result.
- quotient_o  output  XLEN  quotient.
- remainder_o  output  XLEN  remainder.

Behaviour:
- Reset (rst==0 at an edge): state=IDLE, resp_valid_o=0, req_ready_o=1, quotient_o=0, remainder_o=0. All internal registers are cleared.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE: req_ready_o=1.
  - req_valid_i&&!block_i&&!flush_i: latch op_1_i, op_2_i, signed_i, word_i and go to PREP.
- Width rule: effective width W = word_i ? XLEN/2 : XLEN.
  - Operands are truncated to their low W bits.
  - If signed_i, operands are sign-interpreted at bit W-1; otherwise they are unsigned.
- PREP (1 cycle):
  - Compute |op_1| and |op_2| (W+1 bits).
  - Record sign_q = sign1^sign2 and sign_r = sign1 (both 0 when unsigned).
  - Load remainder=0, quotient=|op_1|, counter=W.
  - Divisor==0: result quotient=all ones (W bits), remainder=op_1 (W bits). Go to DONE.
  - Signed overflow (op_1 == -2^(W-1), op_2 == -1): quotient=op_1, remainder=0. Go to DONE.
  - Otherwise go to CALC.
- CALC (exactly W cycles): restoring radix-2 step per cycle.
  - Form trial {remainder, quotient[msb]} minus divisor.
  - If the result is non-negative: remainder=trial and shift 1 into quotient; else shift remainder left and shift 0 into quotient.
  - counter decrements; at counter==1 go to FIX.
- FIX (1 cycle):
  - Negate quotient if sign_q; negate remainder if sign_r.
  - Word mode: sign-extend both results from bit W-1 to XLEN, including the unsigned case (RV64 DIVUW/REMUW semantics).
  - Go to DONE.
- Special-case results take the same word-mode sign-extension before DONE.
- DONE: resp_valid_o=1, and quotient_o/remainder_o are held stable.
  - resp_ready_i&&!block_i: go to IDLE.
  - Back-to-back issue: a new request is accepted only from IDLE, so there is at least 1 idle cycle between operations.
- Latency (acceptance edge to first cycle with resp_valid_o=1):
  - Normal: W+2 cycles (1 PREP, W CALC, 1 FIX). That is 66 for XLEN=64, 34 for word mode.
  - Special cases: 1 cycle.
- Outputs are registered; quotient_o/remainder_o are only meaningful while resp_valid_o=1. They are not cleared on return to IDLE.
- block_i=1: every register holds, including the counter and state. resp_valid_o keeps its value, and neither a handshake nor an acceptance occurs.
- flush_i=1 (any state): next state IDLE, resp_valid_o=0 next cycle, no request accepted that cycle. flush_i overrides block_i.
- rst==0 mid-operation behaves like flush and also clears the datapath.
- Simultaneous resp_ready_i and req_valid_i in DONE: the response completes and the request is not accepted until IDLE.

Test Plan:
- Unsigned XLEN=64: op_1=100, op_2=7, signed=0, word=0 -> q=14, r=2. resp_valid_o first high exactly 66 cycles after acceptance.
- Signed sign mix: op_1=-7, op_2=2 -> q=-3 (0xFFFF_FFFF_FFFF_FFFD), r=-1. Also op_1=7, op_2=-2 -> q=-3, r=1.
- Special cases:
  - op_2=0, op_1=0x1234 -> q=0xFFFF_FFFF_FFFF_FFFF, r=0x1234, 1-cycle latency.
  - op_1=0x8000_0000_0000_0000, op_2=-1, signed -> q=op_1, r=0.
- Word mode:
  - op_1=0xDEAD_0000_8000_0000, op_2=1, unsigned -> q=0xFFFF_FFFF_8000_0000 (sign-extended), latency 34.
  - Signed op_1=0x0000_0000_FFFF_FFF9 (-7), op_2=2 -> q=0xFFFF_FFFF_FFFF_FFFD, r=0xFFFF_FFFF_FFFF_FFFF.
- Stall/backpressure: block_i high for 5 cycles mid-CALC -> latency grows by exactly 5 and the result is unchanged. With resp_ready_i low for 10 cycles in DONE, resp_valid_o and the outputs stay stable, and req_ready_o=0 throughout.
- Flush/reset:
  - flush_i pulse at CALC cycle 20 -> resp_valid_o never asserts, and req_ready_o=1 next cycle.
  - A new request then returns a correct result.
  - rst=0 for 1 cycle mid-CALC -> all outputs are at reset values.
